// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the toggle (two-phase) request/acknowledge bus crossing.
// Used by both the transmit and receive halves.
package cdc_handshake_tx_pkg;

  // Handshake FSM states
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } cdc_state_e;

  // Width of the completed-transfer counter
  localparam int unsigned XFER_CNT_W = 16;

  // Legal range of synchronizer depth
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Timeout counter width; a zero timeout keeps a one-bit counter
  function automatic int unsigned to_cnt_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_toggle_sync.sv
// toggle_sync: multi-flop synchronizer for a toggle signal, plus edge detect.
// Ports:
//   clk, rst  - destination clock, async active-low reset
//   din       - asynchronous toggle input
//   level     - synchronized level (last sync stage)
//   pulse_c   - one-cycle pulse whenever the synchronized level changes
module toggle_sync
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic pulse_c
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("toggle_sync: STAGES out of legal range");
  end

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  // Synchronizer chain plus one delay register for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      level_d <= sync_q[STAGES-1];
    end
  end

  assign level   = sync_q[STAGES-1];
  assign pulse_c = sync_q[STAGES-1] ^ level_d;

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source half of a two-phase request/acknowledge crossing.
// Accepts a word on in_valid/in_ready, holds it on tx_data, toggles tx_req and
// waits for the synchronized rx_ack toggle before accepting the next word.
// Ports:
//   clk, rst              - source clock, async active-low reset
//   in_data/in_valid/in_ready - word input handshake (ready only in IDLE)
//   tx_data, tx_req       - held word and request toggle to the destination
//   rx_ack                - acknowledge toggle from the destination (async)
//   busy                  - waiting for acknowledge
//   xfer_cnt              - completed transfers, wrapping
//   err_timeout, err_proto - sticky error flags
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATAWIDTH-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATAWIDTH-1:0]  tx_data,
  output logic                  tx_req,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  err_timeout,
  output logic                  err_proto
);

  localparam int unsigned      TO_W   = to_cnt_width(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT);

  cdc_state_e      state;
  logic [TO_W-1:0] to_cnt;
  logic            ack_s;
  logic            ack_evt_c;
  logic            unused_ok;

  toggle_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .din     (rx_ack),
    .level   (ack_s),
    .pulse_c (ack_evt_c)
  );

  // Only the edge of the acknowledge matters, never its level
  assign unused_ok = ack_s;

  // Handshake FSM with registered outputs, timeout counter and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_data     <= '0;
      tx_req      <= 1'b0;
      to_cnt      <= '0;
      xfer_cnt    <= '0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      // An acknowledge while nothing is outstanding is a protocol error
      if (ack_evt_c && state == IDLE) begin
        err_proto <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            tx_data  <= in_data;
            tx_req   <= ~tx_req;
            to_cnt   <= '0;
            state    <= WAIT_ACK;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_evt_c) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            xfer_cnt <= xfer_cnt + XFER_CNT_W'(1);
          end else if (TIMEOUT != 0 && to_cnt != TO_MAX) begin
            // Saturating count; the transfer keeps waiting after a timeout
            to_cnt <= to_cnt + TO_W'(1);
            if (to_cnt == TO_MAX - TO_W'(1)) begin
              err_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-domain half of the two-phase (toggle) request/acknowledge bus crossing used between the async FIFO's clock domains and for slow control/status words that do not justify a FIFO. It accepts a word on a valid/ready interface and holds it stable on `tx_data`. It toggles `tx_req`, then waits until the destination's `rx_ack` toggle has been synchronized into `clk` before it accepts the next word. It also flags acknowledge timeouts and protocol violations.

## Interface
- `DATAWIDTH`, 4: width of the transferred word.
- `SYNC_STAGES`, 2: flop stages on `rx_ack` (legal range 2..4).
- `TIMEOUT`, 1024: `clk` cycles in WAIT_ACK before `err_timeout` sets; 0 disables the timeout.
- `clk`  in  1  source-domain clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_data`  in  DATAWIDTH  word to send.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `tx_data`  out  DATAWIDTH  registered word to the destination; changes only on accept.
- `tx_req`  out  1  registered request; toggles once per accepted word.
- `rx_ack`  in  1  acknowledge toggle from the destination; asynchronous to `clk`.
- `busy`  out  1  high in WAIT_ACK.
- `xfer_cnt`  out  16  count of completed transfers; wraps 0xFFFF -> 0.
- `err_timeout`  out  1  sticky flag; cleared only by `rst`.
- `err_proto`  out  1  sticky flag (ack toggle seen in IDLE); cleared only by `rst`.

## Operation
- States:
  - IDLE: `in_ready`=1, `busy`=0.
  - WAIT_ACK: `in_ready`=0, `busy`=1.
- Accept: on a `clk` edge with `in_valid` and `in_ready` both high:
  - `tx_data` <= `in_data`.
  - `tx_req` <= ~`tx_req`.
  - timeout counter <= 0.
  - state -> WAIT_ACK.
- Ack path:
  - `rx_ack` passes through SYNC_STAGES reset-to-0 flops to give `ack_s`.
  - One further register gives `ack_d`.
  - `ack_evt` = `ack_s` ^ `ack_d`.
- WAIT_ACK exit: on `ack_evt`, state -> IDLE and `xfer_cnt` increments. The value of `ack_s` is not compared with `tx_req`; only the edge counts.
- `ack_evt` in IDLE: `err_proto` <= 1. State, `tx_req` and `xfer_cnt` are unchanged, and the event is otherwise ignored.
- Timeout (when TIMEOUT>0):
  - The counter increments each cycle in WAIT_ACK and saturates at TIMEOUT.
  - When it reaches TIMEOUT, `err_timeout` <= 1.
  - The block keeps waiting, because a two-phase transfer cannot be aborted safely.
- `tx_data` never changes in WAIT_ACK.
- `in_data` is ignored whenever `in_ready`=0.
- Reset mid-transfer: all state returns to reset values immediately. The destination must be reset in the same event. Any stale ack toggle seen afterwards is reported through `err_proto`.

## Timing
- Reset values:
  - state IDLE, `in_ready` 1, `busy` 0.
  - `tx_req` 0, `tx_data` 0.
  - `xfer_cnt` 0, `err_timeout` 0, `err_proto` 0.
  - All sync flops and `ack_d` 0.
- Accept edge E: `tx_req`, `tx_data` and `busy` are updated after E, and `in_ready` drops after E.
- Ack latency: an `rx_ack` toggle first sampled at edge A gives `ack_evt` high during the cycle after edge A+SYNC_STAGES-1. The WAIT_ACK -> IDLE transition and the `xfer_cnt` increment happen at edge A+SYNC_STAGES. With the default, `in_ready` rises 2 edges after the first sampling edge.
- Back-to-back: a word may be accepted on the first edge where `in_ready`=1. No idle cycle is required.
- Minimum period per word: 1 accept cycle plus the destination's turnaround plus SYNC_STAGES cycles.
- `ack_evt` coinciding with an accept cannot happen in a legal flow. If it does, the accept wins and `err_proto` sets.
- The timeout counter width is clog2(TIMEOUT+1).

## Structure
- Shared CDC package holds:
  - the state enum (IDLE, WAIT_ACK);
  - the `XFER_CNT_W`=16 constant;
  - the SYNC_STAGES legal-range constants, shared with the receive half.
- Sub-module `toggle_sync`:
  - parameterized stage count, reset-to-0 flops;
  - outputs the synchronized level and a one-cycle edge pulse (`ack_s`, `ack_evt`).
  - The receive half reuses it for `tx_req`.
- Top level contains the FSM, the data/req registers, the timeout counter, `xfer_cnt` and the error flags.

## Test plan
- Reset release, `in_valid`=0 -> `in_ready`=1, `tx_req`=0, `tx_data`=0, `xfer_cnt`=0, both error flags 0.
- Send 0xA with the ack model toggling `rx_ack` 3 cycles after `tx_req` changes -> `tx_req` goes 0->1 and `tx_data`=0xA one edge after accept. `in_ready` returns 2 edges after `rx_ack` is first sampled, and `xfer_cnt`=1.
- Stream 0x1..0xF back-to-back with `in_valid` held high -> 15 `tx_req` toggles, `tx_data` stable throughout each WAIT_ACK, `xfer_cnt`=15. Preload `xfer_cnt` to 0xFFFF and verify it wraps to 0.
- TIMEOUT=8, no ack -> `err_timeout` rises exactly 8 cycles after accept and stays high. A late ack then completes the transfer normally.
- Toggle `rx_ack` while IDLE -> `err_proto`=1, `xfer_cnt` unchanged, `tx_req` unchanged, next transfer completes normally.
- Assert `rst` in WAIT_ACK with `tx_req`=1 -> all outputs at reset values immediately. Release reset with `rx_ack`=1 held -> `err_proto`=1 after SYNC_STAGES+1 edges, block stays IDLE.
